// File: rtl/shift_pkg.sv
// Shared definitions for the shift/rotate engine: default widths, op codes, FSM states.
package shift_pkg;

  localparam int unsigned OPSIZE_DEF = 2;
  localparam int unsigned DSIZE_DEF  = 16;
  localparam int unsigned ASIZE_DEF  = 4;

  localparam logic [1:0] OP_SHR = 2'b00;
  localparam logic [1:0] OP_SHL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Single-position shift/rotate of a data word; purely combinational.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned OPSIZE = OPSIZE_DEF,
  parameter int unsigned DSIZE  = DSIZE_DEF
) (
  input  logic [DSIZE-1:0]  f_i,
  input  logic [OPSIZE-1:0] op_i,
  output logic [DSIZE-1:0]  res_c
);

  always_comb begin
    res_c = f_i;
    case (op_i)
      OP_SHR: res_c = {1'b0, f_i[DSIZE-1:1]};
      OP_SHL: res_c = {f_i[DSIZE-2:0], 1'b0};
      OP_ROR: res_c = {f_i[0], f_i[DSIZE-1:1]};
      OP_ROL: res_c = {f_i[DSIZE-2:0], f_i[DSIZE-1]};
      default: res_c = f_i;
    endcase
  end

endmodule

// File: rtl/shift_seq_engine.sv
// Iterative shift/rotate engine: accepts one request, steps one position per clock,
// and holds the result until the consumer takes it.
module shift_seq_engine
  import shift_pkg::*;
#(
  parameter int unsigned OPSIZE = OPSIZE_DEF,
  parameter int unsigned DSIZE  = DSIZE_DEF,
  parameter int unsigned ASIZE  = ASIZE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DSIZE-1:0]  data_b,
  input  logic [OPSIZE-1:0] op,
  input  logic [ASIZE-1:0]  amt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DSIZE-1:0]  f,
  output logic              busy
);

  state_e              state_q, state_d;
  logic [DSIZE-1:0]    f_q, f_d;
  logic [OPSIZE-1:0]   op_q, op_d;
  logic [ASIZE-1:0]    count_q, count_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic [DSIZE-1:0]    step_c;

  shift_step #(
    .OPSIZE (OPSIZE),
    .DSIZE  (DSIZE)
  ) u_step (
    .f_i   (f_q),
    .op_i  (op_q),
    .res_c (step_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      f_q         <= '0;
      op_q        <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      f_q         <= f_d;
      op_q        <= op_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Handshake flags are decoded from the next state so they are registered alongside it.
  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    op_d    = op_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          f_d     = data_b;
          op_d    = op;
          count_d = amt;
          state_d = (amt == ASIZE'(0)) ? DONE : RUN;
        end
      end
      RUN: begin
        f_d     = step_c;
        count_d = count_q - ASIZE'(1);
        if (count_q == ASIZE'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  assign f         = f_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_shift_seq_engine.sv
// Self-checking bench for shift_seq_engine against a shift-operator reference model.
module tb_shift_seq_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_b;
  logic [1:0]  op;
  logic [3:0]  amt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] f;
  logic        busy;

  int checks = 0;
  int errors = 0;

  shift_seq_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_b    (data_b),
    .op        (op),
    .amt       (amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Whole-amount shift computed directly with shift operators on a doubled word.
  function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [1:0] o,
                                            input int a);
    logic [31:0] dd;
    dd = {d, d};
    case (o)
      2'b00: return 16'(d >> a);
      2'b01: return 16'(d << a);
      2'b10: begin dd = dd >> a; return dd[15:0]; end
      default: begin dd = dd << a; return dd[31:16]; end
    endcase
  endfunction

  // Present a request at a negedge; it is accepted on the following posedge.
  task automatic issue(input logic [15:0] d, input logic [1:0] o, input logic [3:0] a);
    @(negedge clk);
    data_b = d; op = o; amt = a; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_b = 16'($urandom); op = 2'($urandom); amt = 4'($urandom);
  endtask

  // Returns the cycle index (1 = first cycle after accept) where out_valid is seen.
  task automatic wait_result(output int lat, output logic [15:0] res);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = f;
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    data_b = '0; op = '0; amt = '0;
    #12;
    checks++;
    if (f !== 16'h0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: f=%h ov=%b busy=%b ir=%b, want 0000 0 0 1",
               f, out_valid, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h1234, 2'b11, 4'd8);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (f !== 16'h0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: f=%h ov=%b busy=%b, want 0000 0 0", f, out_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_no_result: active cycles=%0d want 0", seen);
    end
  endtask

  task automatic test_rotate_right();
    int lat;
    logic [15:0] res;
    issue(16'h8001, 2'b10, 4'd4);
    wait_result(lat, res);
    checks++;
    if (lat !== 5 || res !== 16'h1800) begin
      errors++;
      $display("FAIL ror4: lat=%0d f=%h, want lat=5 f=1800", lat, res);
    end
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ror4_flags: busy=%b ir=%b want 1 0", busy, in_ready);
    end
    handshake();
  endtask

  task automatic test_full_range();
    int lat;
    logic [15:0] res;
    issue(16'hF00F, 2'b01, 4'd15);
    wait_result(lat, res);
    checks++;
    if (lat !== 16 || res !== 16'h8000) begin
      errors++;
      $display("FAIL shl15: lat=%0d f=%h, want lat=16 f=8000", lat, res);
    end
    handshake();
    issue(16'h8000, 2'b00, 4'd15);
    wait_result(lat, res);
    checks++;
    if (lat !== 16 || res !== 16'h0001) begin
      errors++;
      $display("FAIL shr15: lat=%0d f=%h, want lat=16 f=0001", lat, res);
    end
    handshake();
  endtask

  task automatic test_zero_amt();
    int lat;
    logic [15:0] res;
    issue(16'hA5A5, 2'($urandom), 4'd0);
    wait_result(lat, res);
    checks++;
    if (lat !== 1 || res !== 16'hA5A5) begin
      errors++;
      $display("FAIL amt0: lat=%0d f=%h, want lat=1 f=a5a5", lat, res);
    end
    for (int i = 0; i < 3; i++) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b1 || f !== 16'hA5A5) begin
      errors++;
      $display("FAIL amt0_hold: busy=%b ov=%b f=%h want 1 1 a5a5", busy, out_valid, f);
    end
    handshake();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL amt0_release: busy=%b ov=%b ir=%b want 0 0 1", busy, out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    logic [15:0] res;
    issue(16'h8000, 2'b11, 4'd1);
    wait_result(lat, res);
    checks++;
    if (lat !== 2 || res !== 16'h0001) begin
      errors++;
      $display("FAIL rol1: lat=%0d f=%h, want lat=2 f=0001", lat, res);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; data_b = 16'($urandom); op = 2'($urandom); amt = 4'($urandom);
      @(negedge clk);
      if (f !== 16'h0001 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL backpressure_hold: bad cycles=%0d want 0", bad);
    end
    handshake();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: ir=%b ov=%b busy=%b want 1 0 0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [15:0] res;
    logic [15:0] d2;
    d2 = 16'($urandom);
    @(negedge clk);
    data_b = 16'h00F0; op = 2'b10; amt = 4'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    data_b = d2; op = 2'b01; amt = 4'd5;
    wait_result(lat, res);
    checks++;
    if (lat !== 4 || res !== ref_shift(16'h00F0, 2'b10, 3)) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d f=%h, want lat=4 f=%h", lat, res,
               ref_shift(16'h00F0, 2'b10, 3));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: ir=%b busy=%b want 1 0", in_ready, busy);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(lat, res);
    checks++;
    if (lat !== 6 || res !== ref_shift(d2, 2'b01, 5)) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d f=%h, want lat=6 f=%h", lat, res,
               ref_shift(d2, 2'b01, 5));
    end
    handshake();
  endtask

  task automatic test_random();
    int lat;
    int bad;
    int stall;
    logic [15:0] res, d, exp;
    logic [1:0] o;
    logic [3:0] a;
    bad = 0;
    for (int n = 0; n < 30; n++) begin
      d = 16'($urandom); o = 2'($urandom); a = 4'($urandom);
      exp = ref_shift(d, o, int'(a));
      issue(d, o, a);
      wait_result(lat, res);
      if (lat != int'(a) + 1 || res !== exp) begin
        bad++;
        $display("FAIL random_txn %0d: d=%h op=%0d amt=%0d lat=%0d f=%h, want lat=%0d f=%h",
                 n, d, o, a, lat, res, int'(a) + 1, exp);
      end
      stall = int'($urandom_range(0, 3));
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        if (f !== exp || out_valid !== 1'b1) bad++;
      end
      handshake();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL random_summary: bad=%0d want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_rotate_right();
    test_full_range();
    test_zero_amt();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
